// File: rtl/amci_pkg.sv
// Shared definitions for the AMCI command sequencer: port bit offsets, opcodes
// and the sequencer state encoding.
package amci_pkg;

    localparam int MOSI_W    = 98;
    localparam int MISO_W    = 34;

    localparam int WADDR_LSB = 0;
    localparam int WDATA_LSB = 32;
    localparam int RADDR_LSB = 64;
    localparam int WRITE_BIT = 96;
    localparam int READ_BIT  = 97;

    localparam int RDATA_LSB = 0;
    localparam int WIDLE_BIT = 32;
    localparam int RIDLE_BIT = 33;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;
    localparam logic [1:0] OP_POLL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_GAP,
        S_RSP
    } seq_state_e;

    function automatic logic [31:0] rmw_merge(input logic [31:0] orig,
                                              input logic [31:0] ins,
                                              input logic [31:0] mask);
        return (orig & ~mask) | (ins & mask);
    endfunction

endpackage

// File: rtl/amci_port_driver.sv
// Single-access engine for the AMCI port: registered one-cycle write/read pulses
// and completion detection against the master's idle flags.
module amci_port_driver
    import amci_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_go_i,
    input  logic              rd_go_i,
    input  logic [31:0]       waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       raddr_i,
    input  logic [MISO_W-1:0] miso_i,
    output logic [MOSI_W-1:0] mosi_o,
    output logic              wr_done_o,
    output logic              rd_done_o,
    output logic [31:0]       rdata_o
);

    logic write_q;
    logic read_q;
    logic wr_busy_q;
    logic rd_busy_q;
    logic settle_q;

    // The master lowers its idle flag only one cycle after the pulse, so the
    // first waiting cycle is never allowed to complete.
    assign wr_done_o = wr_busy_q & ~settle_q & miso_i[WIDLE_BIT];
    assign rd_done_o = rd_busy_q & ~settle_q & miso_i[RIDLE_BIT];
    assign rdata_o   = miso_i[RDATA_LSB +: 32];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            wr_busy_q <= 1'b0;
            rd_busy_q <= 1'b0;
            settle_q  <= 1'b0;
        end else begin
            write_q  <= wr_go_i;
            read_q   <= rd_go_i & ~wr_go_i;
            settle_q <= write_q | read_q;
            if (write_q)
                wr_busy_q <= 1'b1;
            else if (wr_done_o)
                wr_busy_q <= 1'b0;
            if (read_q)
                rd_busy_q <= 1'b1;
            else if (rd_done_o)
                rd_busy_q <= 1'b0;
        end
    end

    // NOTE: a full default before any partial assignment keeps always_comb
    // free of inferred latches.
    always_comb begin
        mosi_o                     = '0;
        mosi_o[WADDR_LSB +: 32]    = waddr_i;
        mosi_o[WDATA_LSB +: 32]    = wdata_i;
        mosi_o[RADDR_LSB +: 32]    = raddr_i;
        mosi_o[WRITE_BIT]          = write_q;
        mosi_o[READ_BIT]           = read_q;
    end

endmodule

// File: rtl/amci_cmd_sequencer.sv
// Command/response front end for the AMCI port: WRITE, READ, read-modify-write
// and poll-until-match, one response per accepted command.
module amci_cmd_sequencer
    import amci_pkg::*;
#(
    parameter int POLL_TIMEOUT = 100000,
    parameter int TMO_WIDTH    = 32,
    parameter int POLL_GAP     = 4
)(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [97:0] AMCI_MOSI,
    input  logic [33:0] AMCI_MISO
);

    localparam int                   GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(POLL_TIMEOUT);

    seq_state_e           state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          mask_q, mask_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [TMO_WIDTH-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;

    logic        wr_done;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        poll_match;

    assign poll_match = (rd_data & mask_q) == (data_q & mask_q);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        gap_d         = gap_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d          = cmd_op;
                    addr_d        = cmd_addr;
                    data_d        = cmd_data;
                    mask_d        = cmd_mask;
                    wdata_d       = cmd_data;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = (cmd_op == OP_WRITE) ? S_WR_ISSUE : S_RD_ISSUE;
                end
            end
            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (wr_done) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_done) begin
                    rsp_data_d = rd_data;
                    if (op_q == OP_RMW) begin
                        wdata_d = rmw_merge(rd_data, data_q, mask_q);
                        state_d = S_WR_ISSUE;
                    end else if (op_q != OP_POLL || poll_match) begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RSP;
                    end else if (cnt_q >= TMO_LIMIT) begin
                        rsp_valid_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = S_RSP;
                    end else begin
                        gap_d   = '0;
                        state_d = (POLL_GAP == 0) ? S_RD_ISSUE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = S_RD_ISSUE;
                else
                    gap_d = gap_q + 1'b1;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready is registered; gating on both idle flags keeps a freshly reset
        // block from issuing while the master finishes an older transfer.
        cmd_ready_d = (state_d == S_IDLE) & AMCI_MISO[WIDLE_BIT] & AMCI_MISO[RIDLE_BIT] & ~rsp_valid_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= S_IDLE;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            wdata_q       <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            wdata_q       <= wdata_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
        end
    end

    amci_port_driver u_port (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .wr_go_i   (state_d == S_WR_ISSUE),
        .rd_go_i   (state_d == S_RD_ISSUE),
        .waddr_i   (addr_q),
        .wdata_i   (wdata_q),
        .raddr_i   (addr_q),
        .miso_i    (AMCI_MISO),
        .mosi_o    (AMCI_MOSI),
        .wr_done_o (wr_done),
        .rd_done_o (rd_done),
        .rdata_o   (rd_data)
    );

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_amci_cmd_sequencer.sv
// Directed bench for amci_cmd_sequencer against a behavioural AMCI master with
// a small register RAM and random 0-5 cycle completion delays.
module tb_amci_cmd_sequencer;
    import amci_pkg::*;

    localparam int TMO = 50;
    localparam int GAP = 4;
    localparam int TMO_SLACK = 14;  // gap + issue + longest modelled read

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data, cmd_mask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [97:0] mosi;
    logic [33:0] miso;

    always #5 clk = ~clk;

    amci_cmd_sequencer #(.POLL_TIMEOUT(TMO), .TMO_WIDTH(32), .POLL_GAP(GAP)) dut (
        .ACLK        (clk),
        .ARESET      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .AMCI_MOSI   (mosi),
        .AMCI_MISO   (miso)
    );

    // Behavioural AMCI master: it is not reset with the DUT, so a transfer in
    // flight across a DUT reset keeps its idle flag low until it completes.
    logic        widle_m = 1'b1;
    logic        ridle_m = 1'b1;
    logic [31:0] rdata_m = '0;
    logic [31:0] mem [64];
    logic        mem_clr = 1'b1;
    logic [5:0]  widx, ridx;
    logic [31:0] wval;
    int unsigned wdl, rdl;
    int unsigned force_wdly = 0;
    int          wr_pulses = 0, rd_pulses = 0, overlap = 0, long_pulse = 0, poll_reads = 0;
    logic        prev_w = 1'b0, prev_r = 1'b0;
    int          cyc = 0;

    assign miso = {ridle_m, widle_m, rdata_m};

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        prev_w <= mosi[WRITE_BIT];
        prev_r <= mosi[READ_BIT];
        if (mosi[WRITE_BIT] && mosi[READ_BIT]) overlap <= overlap + 1;
        if ((mosi[WRITE_BIT] && prev_w) || (mosi[READ_BIT] && prev_r)) long_pulse <= long_pulse + 1;
        if (mem_clr)
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        if (mosi[WRITE_BIT]) begin
            wr_pulses <= wr_pulses + 1;
            widle_m   <= 1'b0;
            widx      <= mosi[WADDR_LSB+2 +: 6];
            wval      <= mosi[WDATA_LSB +: 32];
            wdl       <= (force_wdly != 0) ? force_wdly : $urandom_range(0, 5);
        end else if (!widle_m) begin
            if (wdl == 0) begin
                mem[widx] <= wval;
                widle_m   <= 1'b1;
            end else begin
                wdl <= wdl - 1;
            end
        end
        if (mosi[READ_BIT]) begin
            rd_pulses <= rd_pulses + 1;
            ridle_m   <= 1'b0;
            ridx      <= mosi[RADDR_LSB+2 +: 6];
            rdl       <= $urandom_range(0, 5);
        end else if (!ridle_m) begin
            if (rdl == 0) begin
                rdata_m <= mem[ridx];
                ridle_m <= 1'b1;
                if (ridx == 6'd12) begin  // register 0x30: bit0 sets after its 3rd read
                    poll_reads <= poll_reads + 1;
                    if (poll_reads == 2) mem[ridx] <= mem[ridx] | 32'h1;
                end
            end else begin
                rdl <= rdl - 1;
            end
        end
    end

    int n_cmp = 0;
    int n_mis = 0;
    int acc_cyc, rsp_cyc;

    task automatic check(input string tag, input logic [97:0] obs, input logic [97:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] m);
        logic acc;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (cmd_ready) begin
                acc     = 1'b1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", acc, 1'b1);
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic t);
        logic got;
        got = 1'b0;
        d = 'x; t = 1'bx;
        for (int i = 0; i < 400 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1; rsp_cyc = cyc; d = rsp_data; t = rsp_timeout;
            end else begin
                @(negedge clk);
            end
        end
        check("rsp_arrived", got, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] dat,
                          input logic [31:0] m, output logic [31:0] d, output logic t);
        send(op, a, dat, m);
        get_rsp(d, t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        t;
        int          w0, r0, n;

        cmd_valid = 1'b0; cmd_op = OP_WRITE; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
        rsp_ready = 1'b0;
        areset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_rsp", {rsp_valid, rsp_timeout, rsp_data}, 34'h0);
        check("reset_mosi", mosi, 98'h0);
        mem_clr = 1'b0;
        areset  = 1'b0;
        @(negedge clk);

        // WRITE then READ round trip with exact pulse accounting.
        w0 = wr_pulses; r0 = rd_pulses;
        do_cmd(OP_WRITE, 32'h10, 32'hDEADBEEF, 32'h0, d, t);
        check("write_rsp", {t, d}, {1'b0, 32'h0});
        check("write_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd1, 32'd0});
        w0 = wr_pulses; r0 = rd_pulses;
        do_cmd(OP_READ, 32'h10, 32'h0, 32'h0, d, t);
        check("read_rsp", {t, d}, {1'b0, 32'hDEADBEEF});
        check("read_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd0, 32'd1});

        // Read-modify-write replaces byte 1 only.
        do_cmd(OP_WRITE, 32'h20, 32'h12345678, 32'h0, d, t);
        w0 = wr_pulses; r0 = rd_pulses;
        do_cmd(OP_RMW, 32'h20, 32'h0000AB00, 32'h0000FF00, d, t);
        check("rmw_rsp_orig", {t, d}, {1'b0, 32'h12345678});
        check("rmw_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd1, 32'd1});
        do_cmd(OP_READ, 32'h20, 32'h0, 32'h0, d, t);
        check("rmw_result", d, 32'h1234AB78);

        // Poll succeeds on the 4th read.
        r0 = rd_pulses;
        do_cmd(OP_POLL, 32'h30, 32'h1, 32'h1, d, t);
        check("poll_rsp", {t, d}, {1'b0, 32'h1});
        check("poll_reads", rd_pulses - r0, 32'd4);

        // Poll that never matches ends by timeout within one access of the limit.
        do_cmd(OP_POLL, 32'h40, 32'h1, 32'h1, d, t);
        check("poll_tmo_rsp", {t, d}, {1'b1, 32'h0});
        check("poll_tmo_latency_in_window",
              (rsp_cyc - acc_cyc >= TMO) && (rsp_cyc - acc_cyc <= TMO + TMO_SLACK), 1'b1);

        // Back-pressure: response held, no new command accepted.
        send(OP_READ, 32'h10, 32'h0, 32'h0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_op = OP_READ; cmd_addr = 32'h20; cmd_data = '0; cmd_mask = '0; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_stable", {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b0, 32'hDEADBEEF});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("b2b_ready_after_handshake", {rsp_valid, cmd_ready}, 2'b01);
        do_cmd(OP_READ, 32'h20, 32'h0, 32'h0, d, t);
        check("after_hold_read", d, 32'h1234AB78);

        // Reset during WR_WAIT while the master still owns a slow write.
        force_wdly = 15;
        send(OP_WRITE, 32'h50, 32'hA5A5A5A5, 32'h0);
        repeat (2) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check("midop_reset_rsp", {cmd_ready, rsp_valid, rsp_timeout, rsp_data}, 35'h0);
        check("midop_reset_mosi", mosi, 98'h0);
        @(negedge clk);
        areset     = 1'b0;
        force_wdly = 0;
        check("widle_low_after_reset", widle_m, 1'b0);
        n = 0;
        while (!widle_m && n < 100) begin
            check("ready_gated_by_widle", cmd_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!cmd_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_idle", cmd_ready, 1'b1);
        do_cmd(OP_WRITE, 32'h54, 32'h0BADF00D, 32'h0, d, t);
        check("post_reset_write_rsp", {t, d}, {1'b0, 32'h0});
        do_cmd(OP_READ, 32'h54, 32'h0, 32'h0, d, t);
        check("post_reset_read", d, 32'h0BADF00D);

        check("pulse_overlap_count", overlap, 32'd0);
        check("long_pulse_count", long_pulse, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
